// File: rtl/countdown_timer_pkg.sv
// +------------------------------------------------------------------+
// | countdown_timer_pkg : shared timer state type and BCD constants  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package countdown_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_EXPIRED = 3'd4
  } timer_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Out-of-range configuration digits saturate to the largest BCD digit.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/countdown_timer_bcd_digit_dec.sv
// +------------------------------------------------------------------+
// | bcd_digit_dec : combinational single-digit BCD decrement/borrow  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module bcd_digit_dec
  import countdown_timer_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [3:0] dec_o,
  output logic       borrow_o
);

  assign borrow_o = (val_i == 4'd0);
  assign dec_o    = borrow_o ? BCD_MAX : (val_i - 4'd1);

endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
// +------------------------------------------------------------------+
// | countdown_timer : two-digit BCD countdown with prescaler and FSM |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reconfig_i,
  input  logic       enable_i,
  input  logic       clear_i,
  input  logic [3:0] cfg_tens_i,
  input  logic [3:0] cfg_ones_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       time_out_pulse_o,
  output logic       running_o
);

  localparam int                 PRESC_W    = $clog2(TICKS_PER_SEC);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  timer_state_e       state_q, state_d;
  logic [3:0]         tens_q, tens_d, ones_q, ones_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               pulse_q, pulse_d;
  logic               running_q;

  logic [3:0] ones_dec, tens_dec;
  logic       ones_borrow, tens_borrow;

  bcd_digit_dec u_dec_ones (
    .val_i   (ones_q),
    .dec_o   (ones_dec),
    .borrow_o(ones_borrow)
  );

  bcd_digit_dec u_dec_tens (
    .val_i   (tens_q),
    .dec_o   (tens_dec),
    .borrow_o(tens_borrow)
  );

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    pulse_d = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = '0;
    end else if (reconfig_i) begin
      state_d = ST_LOADED;
      tens_d  = clamp_bcd(cfg_tens_i);
      ones_d  = clamp_bcd(cfg_ones_i);
      presc_d = '0;
    end else begin
      case (state_q)
        ST_LOADED: begin
          if (enable_i) begin
            if (tens_q == 4'd0 && ones_q == 4'd0) begin
              state_d = ST_EXPIRED;
              pulse_d = 1'b1;
            end else begin
              state_d = ST_RUNNING;
            end
          end
        end
        ST_PAUSED: begin
          if (enable_i) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (!enable_i) begin
            state_d = ST_PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            // Both digits borrowing would wrap 00 to 99; that count never runs.
            if (!(ones_borrow && tens_borrow)) begin
              ones_d = ones_dec;
              if (ones_borrow) tens_d = tens_dec;
              if (tens_d == 4'd0 && ones_d == 4'd0) begin
                state_d = ST_EXPIRED;
                pulse_d = 1'b1;
              end
            end
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
        ST_IDLE, ST_EXPIRED: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      presc_q   <= '0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      presc_q   <= presc_d;
      pulse_q   <= pulse_d;
      running_q <= (state_d == ST_RUNNING);
    end
  end

  assign tens_o           = tens_q;
  assign ones_o           = ones_q;
  assign time_out_pulse_o = pulse_q;
  assign running_o        = running_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// +------------------------------------------------------------------+
// | tb_countdown_timer : vector table, corner sequences, random+model |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst, reconfig, enable, clear;
  logic [3:0] cfg_tens, cfg_ones;
  logic [3:0] tens, ones;
  logic       pulse, running;

  int n_cmp = 0;
  int n_bad = 0;

  countdown_timer #(.TICKS_PER_SEC(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .reconfig_i      (reconfig),
    .enable_i        (enable),
    .clear_i         (clear),
    .cfg_tens_i      (cfg_tens),
    .cfg_ones_i      (cfg_ones),
    .tens_o          (tens),
    .ones_o          (ones),
    .time_out_pulse_o(pulse),
    .running_o       (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, clr, rc, en;
    logic [3:0] ct, co;
    int         e_val;
    logic       e_p, e_r;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic r, c, rc, e, input logic [3:0] t, o,
                              input int v, input logic p, rn);
    vec_t x;
    x.rst_n = r; x.clr = c; x.rc = rc; x.en = e; x.ct = t; x.co = o;
    x.e_val = v; x.e_p = p; x.e_r = rn;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: actual=%0d required=%0d", nm, $time, act, exp_v);
    end
  endtask

  task automatic chk_all(input string nm, input int v, input logic p, input logic r);
    chk({nm, ".tens"}, int'(tens), v / 10);
    chk({nm, ".ones"}, int'(ones), v % 10);
    chk({nm, ".pulse"}, int'(pulse), int'(p));
    chk({nm, ".running"}, int'(running), int'(r));
  endtask

  task automatic set_in(input logic r, c, rc, e, input logic [3:0] t, o);
    rst = r; clear = c; reconfig = rc; enable = e; cfg_tens = t; cfg_ones = o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: count kept as a plain integer 0..99.
  localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  int   m_count, m_phase, m_pre;
  logic m_pulse;

  task automatic model_step();
    int t, o;
    m_pulse = 1'b0;
    t = (int'(cfg_tens) > 9) ? 9 : int'(cfg_tens);
    o = (int'(cfg_ones) > 9) ? 9 : int'(cfg_ones);
    if (!rst) begin
      m_count = 0; m_pre = 0; m_phase = M_IDLE;
    end else if (clear) begin
      m_count = 0; m_pre = 0; m_phase = M_IDLE;
    end else if (reconfig) begin
      m_count = t * 10 + o; m_pre = 0; m_phase = M_LOADED;
    end else if (m_phase == M_LOADED && enable) begin
      if (m_count == 0) begin m_phase = M_DONE; m_pulse = 1'b1; end
      else m_phase = M_RUN;
    end else if (m_phase == M_PAUSE && enable) begin
      m_phase = M_RUN;
    end else if (m_phase == M_RUN) begin
      if (!enable) m_phase = M_PAUSE;
      else if (m_pre == 3) begin
        m_pre = 0;
        m_count = m_count - 1;
        if (m_count == 0) begin m_phase = M_DONE; m_pulse = 1'b1; end
      end else m_pre = m_pre + 1;
    end
  endtask

  initial begin
    int n_pulse;

    vecs[0]  = mk(0, 0, 0, 0, 4'h0, 4'h0,  0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 0, 4'hA, 4'hF, 99, 0, 0);
    vecs[2]  = mk(1, 0, 0, 1, 4'h0, 4'h0, 99, 0, 1);
    vecs[3]  = mk(1, 0, 0, 1, 4'h0, 4'h0, 99, 0, 1);
    vecs[4]  = mk(1, 0, 0, 1, 4'h0, 4'h0, 99, 0, 1);
    vecs[5]  = mk(1, 0, 0, 1, 4'h0, 4'h0, 99, 0, 1);
    vecs[6]  = mk(1, 0, 0, 1, 4'h0, 4'h0, 98, 0, 1);
    vecs[7]  = mk(1, 1, 1, 1, 4'h3, 4'h4,  0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 1, 4'h0, 4'h0,  0, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 4'h0, 4'h0,  0, 0, 0);
    vecs[10] = mk(1, 0, 0, 1, 4'h0, 4'h0,  0, 1, 0);
    vecs[11] = mk(1, 0, 0, 1, 4'h0, 4'h0,  0, 0, 0);
    vecs[12] = mk(1, 0, 1, 1, 4'h1, 4'h0, 10, 0, 0);
    vecs[13] = mk(1, 0, 0, 1, 4'h0, 4'h0, 10, 0, 1);
    vecs[14] = mk(1, 0, 0, 1, 4'h0, 4'h0, 10, 0, 1);
    vecs[15] = mk(1, 0, 0, 1, 4'h0, 4'h0, 10, 0, 1);
    vecs[16] = mk(1, 0, 0, 1, 4'h0, 4'h0, 10, 0, 1);
    vecs[17] = mk(1, 0, 0, 1, 4'h0, 4'h0,  9, 0, 1);
    vecs[18] = mk(0, 0, 0, 1, 4'h0, 4'h0,  0, 0, 0);
    vecs[19] = mk(1, 0, 0, 1, 4'h0, 4'h0,  0, 0, 0);

    set_in(0, 0, 0, 0, 4'h0, 4'h0);
    step();
    foreach (vecs[i]) begin
      set_in(vecs[i].rst_n, vecs[i].clr, vecs[i].rc, vecs[i].en, vecs[i].ct, vecs[i].co);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_p, vecs[i].e_r);
    end

    // Load 12 and run to expiry: one decrement every 4 cycles, single pulse.
    set_in(1, 0, 1, 0, 4'h1, 4'h2);
    step();
    chk_all("run12.load", 12, 0, 0);
    set_in(1, 0, 0, 1, 4'h0, 4'h0);
    n_pulse = 0;
    for (int k = 1; k <= 52; k++) begin
      step();
      if (pulse) n_pulse++;
      chk_all($sformatf("run12.k%0d", k), (k >= 49) ? 0 : 12 - (k - 1) / 4,
              (k == 49), (k < 49));
    end
    chk("run12.pulse_count", n_pulse, 1);

    // Pause with prescaler at 2; it resumes from 2 rather than restarting.
    set_in(1, 0, 1, 0, 4'h3, 4'h5);
    step();
    set_in(1, 0, 0, 1, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) step();
    chk_all("pause.pre2", 35, 0, 1);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_all($sformatf("pause.hold%0d", k), 35, 0, 0);
    end
    enable = 1'b1;
    step();
    chk_all("pause.resume1", 35, 0, 1);
    step();
    chk_all("pause.resume2", 35, 0, 1);
    step();
    chk_all("pause.resume3", 34, 0, 1);

    // clear wins over reconfig while running at 05; afterwards enable is ignored.
    set_in(1, 0, 1, 0, 4'h0, 4'h5);
    step();
    set_in(1, 0, 0, 1, 4'h0, 4'h0);
    step();
    chk_all("clr.run05", 5, 0, 1);
    set_in(1, 1, 1, 1, 4'h7, 4'h7);
    step();
    chk_all("clr.hit", 0, 0, 0);
    set_in(1, 0, 0, 1, 4'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_all($sformatf("clr.idle%0d", k), 0, 0, 0);
    end

    // Randomized traffic against the reference model.
    set_in(0, 0, 0, 0, 4'h0, 4'h0);
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 4000; k++) begin
      rst      = ($urandom_range(0, 149) != 0);
      clear    = ($urandom_range(0, 59) == 0);
      reconfig = ($urandom_range(0, 24) == 0);
      enable   = ($urandom_range(0, 9) < 8);
      cfg_tens = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 1));
      cfg_ones = 4'($urandom_range(0, 15));
      @(posedge clk);
      model_step();
      #1;
      chk_all($sformatf("rand%0d", k), m_count, m_pulse, (m_phase == M_RUN));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
